fifo_uart_tx: RTL and testbench

- Read-side consumer for the team's synchronous byte FIFO: pops one entry at a time and serialises it as a UART frame (start, DATA_W data bits LSB first, optional even parity, stop) on a single line.
- Sits between the FIFO's read port (read strobe, read_data, empty flag) and the chip-level serial TX pin; it is the draining end that pairs with the existing writer.

---
 rtl/fifo_uart_pkg.sv | 34 +++
 rtl/fifo_uart_tx_bit_timer.sv | 52 +++++
 rtl/fifo_uart_tx.sv | 204 ++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_uart_pkg
//  Description : Types and helpers shared by the FIFO-draining UART
//                transmitter (fifo_uart_tx) and its bit timer.
//                - tx_state_t   : transmitter state encoding
//                - C_LINE_IDLE  : serial line level when idle / stop bit
//                - C_LINE_START : serial line level of the start bit
//                - cnt_width()  : width of a counter that runs 0..limit-1
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

  localparam logic C_LINE_IDLE  = 1'b1;
  localparam logic C_LINE_START = 1'b0;

  // A counter holding values 0..limit-1 needs $clog2(limit) bits, but never
  // fewer than one so that degenerate limits still give a legal vector.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_bit_timer
//  Description : Bit-period divider. Counts 0..CLKS_PER_BIT-1 while enabled
//                (clear low) and raises bit_tick_o during the last clock of
//                each bit period, then restarts from zero on its own.
//  Ports       : clk_i       system clock, rising edge
//                reset_ni    asynchronous active-low reset
//                clear_i     hold the counter at zero (no ticks while high)
//                bit_tick_o  high in the final cycle of a bit period
//  Revision    : 1.0  initial release
// ============================================================================
module tx_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_tick_o = !clear_i && (cnt_q == C_LAST);

  // The counter returns to zero on the tick itself, so it never runs past
  // its terminal value and consecutive bit periods abut exactly.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || bit_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tx_bit_timer
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Read-side consumer of the synchronous byte FIFO. Pops one
//                entry at a time and sends it as a UART frame: start bit,
//                DATA_W data bits LSB first, optional even parity bit, and
//                STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
//  Ports       : clk_i             system clock, rising edge
//                reset_ni          asynchronous active-low reset
//                en_i              allow a new frame (looked at in IDLE only)
//                fifo_empty_i      FIFO empty flag
//                fifo_read_o       one-cycle FIFO pop strobe
//                fifo_read_data_i  FIFO data, valid the cycle after the pop
//                tx_o              serial line, idles high
//                busy_o            high whenever a frame is in progress
//                frame_done_o      one-cycle pulse after the last stop bit
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              fifo_empty_i,
  output logic              fifo_read_o,
  input  logic [DATA_W-1:0] fifo_read_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  // One bit counter serves both the data bits and the stop bits, so it is
  // sized for whichever of the two runs longer.
  localparam int BIT_LIMIT = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BIT_W     = cnt_width(BIT_LIMIT);
  localparam logic [BIT_W-1:0] C_LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] C_LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic              tx_q, tx_d;
  logic              fifo_read_q, fifo_read_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic              timer_clear;
  logic              bit_tick;

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (timer_clear),
    .bit_tick_o (bit_tick)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic. All outputs are registered so the line and
  // the pop strobe are glitch-free; each transition therefore assigns the
  // level the line must carry during the state being entered.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    fifo_read_d  = 1'b0;
    frame_done_d = 1'b0;
    shift_d      = shift_q;
    parity_d     = parity_q;
    bit_d        = bit_q;
    timer_clear  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        tx_d  = C_LINE_IDLE;
        bit_d = '0;
        // Popping is gated by the empty flag here and nowhere else, so a
        // pop can never be issued against an empty FIFO.
        if (en_i && !fifo_empty_i) begin
          state_d     = ST_POP;
          fifo_read_d = 1'b1;
        end
      end

      ST_POP: begin
        // The FIFO pops at the end of this cycle; its data appears next.
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        shift_d  = fifo_read_data_i;
        parity_d = ^fifo_read_data_i;
        tx_d     = C_LINE_START;
        state_d  = ST_START;
      end

      ST_START: begin
        timer_clear = 1'b0;
        if (bit_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        timer_clear = 1'b0;
        if (bit_tick) begin
          if (bit_q == C_LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = C_LINE_IDLE;
              state_d = ST_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      ST_PARITY: begin
        timer_clear = 1'b0;
        if (bit_tick) begin
          bit_d   = '0;
          tx_d    = C_LINE_IDLE;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        timer_clear = 1'b0;
        tx_d        = C_LINE_IDLE;
        // Stop time is counted in whole bit periods on the shared timer.
        if (bit_tick) begin
          if (bit_q == C_LAST_STOP) begin
            bit_d        = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = C_LINE_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers. The asynchronous reset drives the line
  // high at once, so an interrupted frame is never seen as valid data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_q         <= C_LINE_IDLE;
      fifo_read_q  <= 1'b0;
      frame_done_q <= 1'b0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      bit_q        <= '0;
    end else begin
      tx_q         <= tx_d;
      fifo_read_q  <= fifo_read_d;
      frame_done_q <= frame_done_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_q        <= bit_d;
    end
  end

  assign tx_o         = tx_q;
  assign fifo_read_o  = fifo_read_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx. Two instances:
//                u_dut0 : 8N1, 4 clocks per bit
//                u_dut1 : 8E2, 3 clocks per bit
//                Each has a queue-based FIFO model. Expected line waveforms
//                are built from the frame format (start, data LSB first,
//                parity, stops) with arithmetic on the bit index.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB0 = 4;
  localparam int PEN0 = 0;
  localparam int SB0  = 1;
  localparam int CPB1 = 3;
  localparam int PEN1 = 1;
  localparam int SB1  = 2;
  localparam int POP_BUDGET  = 40;
  localparam int LINE_BUDGET = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0;
  logic empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] rdata0 = 8'h00, rdata1 = 8'h00;
  logic rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic pend0 = 1'b0, pend1 = 1'b0;
  logic s_tx[2], s_rd[2], s_busy[2], s_fd[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB0), .PARITY_EN(PEN0), .STOP_BITS(SB0)
  ) u_dut0 (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en0), .fifo_empty_i(empty0),
    .fifo_read_o(rd0), .fifo_read_data_i(rdata0), .tx_o(tx0),
    .busy_o(busy0), .frame_done_o(fd0)
  );

  fifo_uart_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB1), .PARITY_EN(PEN1), .STOP_BITS(SB1)
  ) u_dut1 (
    .clk_i(clk), .reset_ni(reset_n), .en_i(en1), .fifo_empty_i(empty1),
    .fifo_read_o(rd1), .fifo_read_data_i(rdata1), .tx_o(tx1),
    .busy_o(busy1), .frame_done_o(fd1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: FIFO model pops on the edge where the strobe was high, then
  // outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (pend0) begin
      checks++;
      if (fq0.size() == 0) begin
        errors++;
        $display("FAIL pop_while_empty inst0: got pop with 0 entries expected no pop");
      end else rdata0 = fq0.pop_front();
    end
    if (pend1) begin
      checks++;
      if (fq1.size() == 0) begin
        errors++;
        $display("FAIL pop_while_empty inst1: got pop with 0 entries expected no pop");
      end else rdata1 = fq1.pop_front();
    end
    empty0 = (fq0.size() == 0);
    empty1 = (fq1.size() == 0);
    @(negedge clk);
    s_tx[0] = tx0;  s_rd[0] = rd0;  s_busy[0] = busy0;  s_fd[0] = fd0;
    s_tx[1] = tx1;  s_rd[1] = rd1;  s_busy[1] = busy1;  s_fd[1] = fd1;
    pend0 = rd0;
    pend1 = rd1;
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    if (inst == 0) begin fq0.push_back(b); empty0 = 1'b0; end
    else           begin fq1.push_back(b); empty1 = 1'b0; end
  endtask

  task automatic set_en(input int inst, input logic v);
    if (inst == 0) en0 = v; else en1 = v;
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic int frame_len(input int inst);
    return (inst == 0) ? (1 + 8 + PEN0 + SB0) * CPB0 : (1 + 8 + PEN1 + SB1) * CPB1;
  endfunction

  // Waits for the pop, then checks the whole frame on the line against the
  // ideal bit sequence. drop_at >= 0 deasserts en at that line cycle.
  task automatic expect_frame(input int inst, input logic [7:0] d, input logic par,
                              input int exp_len, input int drop_at, output int waited);
    logic bits[16];
    int nb, cpb, pen, sb, c, bad_c, idx;
    logic bad_v, expv;
    bit done;
    cpb = (inst == 0) ? CPB0 : CPB1;
    pen = (inst == 0) ? PEN0 : PEN1;
    sb  = (inst == 0) ? SB0  : SB1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[1 + k] = d[k];
    nb = 9;
    if (pen != 0) begin bits[nb] = par; nb++; end
    for (int k = 0; k < sb; k++) begin bits[nb] = 1'b1; nb++; end

    waited = 0;
    while (s_rd[inst] !== 1'b1 && waited < POP_BUDGET) begin
      cycle();
      waited++;
    end
    check($sformatf("pop_seen inst%0d", inst), 32'(s_rd[inst]), 32'd1);
    if (s_rd[inst] !== 1'b1) return;
    check($sformatf("pop_busy_tx_fd inst%0d", inst), {s_busy[inst], s_tx[inst], s_fd[inst]}, 32'b110);
    cycle();
    check($sformatf("load_rd_tx_busy inst%0d", inst), {s_rd[inst], s_tx[inst], s_busy[inst]}, 32'b011);

    c = 0; bad_c = -1; bad_v = 1'b0; expv = 1'b1; done = 1'b0;
    while (!done && c < LINE_BUDGET) begin
      if (c == drop_at) set_en(inst, 1'b0);
      cycle();
      if (s_fd[inst] === 1'b1) done = 1'b1;
      else begin
        idx = c / cpb;
        if (bad_c < 0) begin
          expv = (idx < nb) ? bits[idx] : 1'b1;
          if (idx >= nb || s_tx[inst] !== expv || s_busy[inst] !== 1'b1) begin
            bad_c = c;
            bad_v = s_tx[inst];
          end
        end
        c++;
      end
    end
    checks++;
    if (bad_c >= 0) begin
      errors++;
      $display("FAIL frame_line inst%0d data=%02h: cycle %0d got tx=%b expected tx=%b busy=1",
               inst, d, bad_c, bad_v, expv);
    end
    check($sformatf("frame_len inst%0d data=%02h", inst, d), 32'(c), 32'(exp_len));
    check($sformatf("done_idle inst%0d", inst), {s_fd[inst], s_busy[inst], s_tx[inst]}, 32'b101);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
    int         len;
    bit         b2b;
  } vec_t;

  initial begin
    vec_t vec[6];
    int   waited;
    bit   ok;
    logic [7:0] rb[3];

    vec[0] = '{inst: 0, data: 8'h55, par: 1'b0, len: 40, b2b: 1'b0};
    vec[1] = '{inst: 0, data: 8'hAA, par: 1'b0, len: 40, b2b: 1'b1};
    vec[2] = '{inst: 0, data: 8'hF0, par: 1'b0, len: 40, b2b: 1'b1};
    vec[3] = '{inst: 1, data: 8'hF0, par: 1'b0, len: 36, b2b: 1'b0};
    vec[4] = '{inst: 1, data: 8'h07, par: 1'b1, len: 36, b2b: 1'b1};
    vec[5] = '{inst: 1, data: 8'h3C, par: 1'b0, len: 36, b2b: 1'b0};

    // ---- reset held with data present and en high ----
    #2 reset_n = 1'b0;
    push(0, 8'h55);
    en0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("reset_hold inst0", {s_tx[0], s_rd[0], s_busy[0], s_fd[0]}, 32'b1000);
    end
    reset_n = 1'b1;
    cycle();
    check("first_pop_after_release", 32'(s_rd[0]), 32'd1);

    // ---- single frame 0x55 ----
    expect_frame(0, 8'h55, 1'b0, 40, -1, waited);
    check("single_frame_wait", 32'(waited), 32'd0);

    // ---- table: back-to-back runs and parity frames ----
    for (int i = 0; i < 6; i++) begin
      if (!vec[i].b2b) begin
        for (int j = i; j < 6 && (j == i || vec[j].b2b); j++) push(vec[j].inst, vec[j].data);
        set_en(vec[i].inst, 1'b1);
        set_en(1 - vec[i].inst, 1'b0);
      end
      expect_frame(vec[i].inst, vec[i].data, vec[i].par, vec[i].len, -1, waited);
      if (vec[i].b2b) check($sformatf("b2b_gap vec%0d", i), 32'(waited), 32'd1);
      if (i == 5 || !vec[i + 1].b2b) check($sformatf("fifo_drained vec%0d", i), 32'(qsize(vec[i].inst)), 32'd0);
    end

    // ---- empty FIFO with en high: no pop ever ----
    en1 = 1'b0;
    en0 = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (s_rd[0] !== 1'b0 || s_tx[0] !== 1'b1 || s_busy[0] !== 1'b0 || s_fd[0] !== 1'b0) ok = 1'b0;
    end
    check("empty_idle_200", 32'(ok), 32'd1);

    // ---- data present but en low: no pop ----
    en0 = 1'b0;
    push(0, 8'h11);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (s_rd[0] !== 1'b0 || s_busy[0] !== 1'b0) ok = 1'b0;
    end
    check("en_low_no_pop", 32'(ok), 32'd1);
    en0 = 1'b1;
    expect_frame(0, 8'h11, 1'b0, 40, -1, waited);

    // ---- en dropped during a data bit of 0xAA ----
    push(0, 8'hAA);
    push(0, 8'h33);
    expect_frame(0, 8'hAA, 1'b0, 40, 13, waited);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (s_rd[0] !== 1'b0 || s_busy[0] !== 1'b0) ok = 1'b0;
    end
    check("en_drop_no_pop", 32'(ok), 32'd1);
    check("en_drop_fifo_left", 32'(qsize(0)), 32'd1);
    en0 = 1'b1;
    expect_frame(0, 8'h33, 1'b0, 40, -1, waited);

    // ---- reset in the 3rd data bit of 0x5A ----
    push(0, 8'h5A);
    waited = 0;
    while (s_rd[0] !== 1'b1 && waited < POP_BUDGET) begin cycle(); waited++; end
    check("midreset_pop_seen", 32'(s_rd[0]), 32'd1);
    cycle();
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (s_fd[0] !== 1'b0) ok = 1'b0;
    end
    check("midreset_bit2_low", 32'(s_tx[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midreset_immediate", {tx0, busy0, fd0, rd0}, 32'b1000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (s_fd[0] !== 1'b0 || s_tx[0] !== 1'b1) ok = 1'b0;
    end
    check("midreset_no_done", 32'(ok), 32'd1);
    reset_n = 1'b1;
    push(0, 8'h3C);
    expect_frame(0, 8'h3C, 1'b0, 40, -1, waited);

    // ---- randomized bursts on both instances ----
    for (int k = 0; k < 12; k++) begin
      int inst, n, gap;
      inst = k % 2;
      set_en(inst, 1'b0);
      set_en(1 - inst, 1'b0);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        rb[j] = 8'($urandom_range(0, 255));
        push(inst, rb[j]);
      end
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) cycle();
      set_en(inst, 1'b1);
      for (int j = 0; j < n; j++) begin
        expect_frame(inst, rb[j], ^rb[j], frame_len(inst), -1, waited);
        if (j > 0) check($sformatf("rand_gap burst%0d", k), 32'(waited), 32'd1);
      end
      check($sformatf("rand_drained burst%0d", k), 32'(qsize(inst)), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_uart_tx
`default_nettype wire
